// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding the decode/control unit.
// Holds the PC, issues one word fetch at a time over a valid/ready request
// channel, and captures the returned word into an IF/ID holding register.
// A redirect flushes the holding register and cancels any in-flight fetch.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   stall_i               decode cannot take the held instruction this cycle
//   redirect_valid_i/pc_i branch/jump taken and its target (low 2 bits ignored)
//   imem_req_valid_o      fetch request valid (only while requesting)
//   imem_req_ready_i      memory accepts the request
//   imem_addr_o           fetch address, always the current PC
//   imem_rsp_valid_i/data response strobe and fetched word
//   if_valid_o            holding register contains a live instruction
//   if_pc_o/if_pc_plus4_o PC of held instruction and its link address
//   if_instr_o            held instruction, NOP_INSTR when empty
//   if_opcode_o/func3_o   decode slices of if_instr_o
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus4_o,
    output logic [31:0] if_instr_o,
    output logic [6:0]  if_opcode_o,
    output logic [2:0]  if_func3_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic              drop;
    logic              req_valid;
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [XLEN-1:0]   if_instr;

    logic              handshake;
    logic [XLEN-1:0]   redirect_target;
    logic              unused_redirect_lsb;

    assign handshake       = req_valid && imem_req_ready_i;
    assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
    // Low target bits are architecturally ignored (no misalignment traps here).
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Fetch FSM; req_valid is kept as a flop that mirrors "state == REQ".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            req_valid <= 1'b0;
            if_valid  <= 1'b0;
            if_pc     <= RESET_PC;
            if_instr  <= NOP_INSTR;
        end else if (redirect_valid_i) begin
            // Redirect beats stall and any response landing this cycle.
            pc       <= redirect_target;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            case (state)
                REQ: begin
                    if (handshake) begin
                        // Accepted request used the old PC; its response is junk.
                        state     <= WAIT;
                        drop      <= 1'b1;
                        req_valid <= 1'b0;
                    end else begin
                        state     <= REQ;
                        req_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid_i) begin
                        state     <= REQ;
                        drop      <= 1'b0;
                        req_valid <= 1'b1;
                    end else begin
                        drop      <= 1'b1;
                    end
                end
                default: begin
                    state     <= REQ;
                    drop      <= 1'b0;
                    req_valid <= 1'b1;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    req_valid <= 1'b1;
                end
                REQ: begin
                    if (handshake) begin
                        state     <= WAIT;
                        req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (drop) begin
                            drop      <= 1'b0;
                            state     <= REQ;
                            req_valid <= 1'b1;
                        end else begin
                            if_instr <= imem_rsp_data_i;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= pc + XLEN'(4);
                            state    <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (!stall_i) begin
                        if_valid  <= 1'b0;
                        if_instr  <= NOP_INSTR;
                        state     <= REQ;
                        req_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid_o = req_valid;
    assign imem_addr_o      = pc;
    assign if_valid_o       = if_valid;
    assign if_pc_o          = if_pc;
    assign if_pc_plus4_o    = if_pc + XLEN'(4);
    assign if_instr_o       = if_instr;
    assign if_opcode_o      = if_instr[6:0];
    assign if_func3_o       = if_instr[14:12];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized phase, all checked against a transaction-level model of the
// fetch rules plus a behavioural instruction memory.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;
    logic [31:0] if_instr_o;
    logic [6:0]  if_opcode_o;
    logic [2:0]  if_func3_o;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_pc_plus4_o    (if_pc_plus4_o),
        .if_instr_o       (if_instr_o),
        .if_opcode_o      (if_opcode_o),
        .if_func3_o       (if_func3_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Memory knobs: 0 = ready always, 1 = random ready, 2 = never ready.
    int ready_mode = 0;
    int lat_min    = 0;
    int lat_max    = 0;

    // Memory-side bookkeeping for the single outstanding request.
    bit          outstanding;
    bit          out_live;
    logic [31:0] out_addr;
    int          lat;

    // Architectural expectations.
    bit          idle_pending;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_fetch;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory side, sample the edge's events, update model, check.
    task automatic cycle();
        bit          p_hs, p_rsp, p_rd, p_st, p_rs, was_live;
        logic [31:0] p_addr, p_tgt;
        case (ready_mode)
            0:       imem_req_ready_i = 1'b1;
            1:       imem_req_ready_i = 1'($urandom_range(0, 1));
            default: imem_req_ready_i = 1'b0;
        endcase
        imem_rsp_valid_i = rst_n && outstanding && (lat == 0);
        imem_rsp_data_i  = imem_rsp_valid_i ? mem_word(out_addr) : 32'($urandom);
        p_hs   = (imem_req_valid_o === 1'b1) && imem_req_ready_i;
        p_addr = imem_addr_o;
        p_rsp  = imem_rsp_valid_i;
        p_rd   = redirect_valid_i;
        p_st   = stall_i;
        p_rs   = rst_n;
        p_tgt  = redirect_pc_i;
        @(posedge clk);
        #1;
        if (!p_rs) begin
            outstanding  = 1'b0;
            idle_pending = 1'b1;
            exp_valid    = 1'b0;
            exp_pc       = RESET_PC;
            exp_instr    = NOP_INSTR;
            exp_fetch    = RESET_PC;
        end else begin
            idle_pending = 1'b0;
            was_live     = out_live;
            if (p_rsp) outstanding = 1'b0;
            else if (outstanding) lat--;
            if (p_rd) begin
                exp_valid = 1'b0;
                exp_instr = NOP_INSTR;
                exp_fetch = {p_tgt[31:2], 2'b00};
                if (outstanding) out_live = 1'b0;
            end else if (p_rsp && was_live) begin
                exp_valid = 1'b1;
                exp_pc    = out_addr;
                exp_instr = mem_word(out_addr);
                exp_fetch = out_addr + 32'd4;
            end else if (exp_valid && !p_st) begin
                exp_valid = 1'b0;
                exp_instr = NOP_INSTR;
            end
            if (p_hs) begin
                outstanding = 1'b1;
                out_addr    = p_addr;
                out_live    = !p_rd;
                lat         = $urandom_range(lat_min, lat_max);
            end
        end
        chk("req_valid", 32'(imem_req_valid_o), 32'(!idle_pending && !outstanding && !exp_valid));
        chk("imem_addr", imem_addr_o, exp_fetch);
        chk("if_valid", 32'(if_valid_o), 32'(exp_valid));
        chk("if_instr", if_instr_o, exp_instr);
        chk("if_opcode", 32'(if_opcode_o), 32'(exp_instr[6:0]));
        chk("if_func3", 32'(if_func3_o), 32'(exp_instr[14:12]));
        if (exp_valid || idle_pending) begin
            chk("if_pc", if_pc_o, exp_pc);
            chk("if_pc_plus4", if_pc_plus4_o, exp_pc + 32'd4);
        end
    endtask

    task automatic run_until_valid(input int budget);
        int n = 0;
        while (!if_valid_o && n < budget) begin
            cycle();
            n++;
        end
        chk("wait_if_valid", 32'(if_valid_o), 32'd1);
    endtask

    task automatic run_until_outstanding(input int budget);
        int n = 0;
        while (!outstanding && n < budget) begin
            cycle();
            n++;
        end
        chk("wait_handshake", 32'(outstanding), 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = tgt;
        cycle();
        redirect_valid_i = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        outstanding      = 1'b0;
        out_live         = 1'b0;
        out_addr         = 32'h0;
        lat              = 0;
        idle_pending     = 1'b1;
        exp_valid        = 1'b0;
        exp_pc           = RESET_PC;
        exp_instr        = NOP_INSTR;
        exp_fetch        = RESET_PC;

        // Reset values.
        repeat (3) cycle();
        chk("rst_if_valid", 32'(if_valid_o), 32'd0);
        chk("rst_if_instr", if_instr_o, 32'h0000_0013);
        chk("rst_if_pc", if_pc_o, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);

        // Single-cycle memory: first fetch and capture.
        rst_n = 1'b1;
        cycle();
        chk("first_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("first_req_addr", imem_addr_o, 32'h0);
        cycle();
        cycle();
        chk("first_instr", if_instr_o, 32'h0050_0093);
        chk("first_opcode", 32'(if_opcode_o), 32'h13);
        chk("first_func3", 32'(if_func3_o), 32'h0);
        chk("first_pc", if_pc_o, 32'h0);
        chk("first_pc_plus4", if_pc_plus4_o, 32'h4);
        cycle();
        chk("second_req_addr", imem_addr_o, 32'h4);

        // Stall while holding the instruction at 0x4.
        run_until_valid(20);
        stall_i = 1'b1;
        repeat (5) cycle();
        chk("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("stall_pc", if_pc_o, 32'h4);
        stall_i = 1'b0;
        cycle();
        chk("unstall_valid", 32'(if_valid_o), 32'd0);
        chk("unstall_addr", imem_addr_o, 32'h8);

        // Redirect while waiting; stale response arrives two cycles later.
        lat_min = 2;
        lat_max = 2;
        run_until_outstanding(20);
        redirect_to(32'h0000_0100);
        run_until_valid(20);
        chk("redir_wait_pc", if_pc_o, 32'h100);

        // Redirect coinciding with a response, then with a request handshake.
        lat_min = 0;
        lat_max = 0;
        cycle();
        run_until_outstanding(20);
        redirect_to(32'h0000_0200);
        redirect_to(32'h0000_0300);
        run_until_valid(20);
        chk("redir_hs_pc", if_pc_o, 32'h300);

        // Unaligned target, then PC wrap.
        stall_i = 1'b1;
        redirect_to(32'h0000_0203);
        stall_i = 1'b0;
        chk("unaligned_addr", imem_addr_o, 32'h200);
        chk("redir_flush", 32'(if_valid_o), 32'd0);
        run_until_valid(20);
        chk("unaligned_pc", if_pc_o, 32'h200);
        redirect_to(32'hFFFF_FFFF);
        run_until_valid(20);
        chk("wrap_pc", if_pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", if_pc_plus4_o, 32'h0);
        cycle();
        chk("wrap_addr", imem_addr_o, 32'h0);

        // Randomized traffic.
        ready_mode = 1;
        lat_min    = 0;
        lat_max    = 3;
        for (int i = 0; i < 3000; i++) begin
            stall_i          = ($urandom_range(0, 9) < 3);
            redirect_valid_i = ($urandom_range(0, 19) == 0);
            redirect_pc_i    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                           : 32'($urandom);
            cycle();
        end
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;

        // Reset in the middle of a fetch, memory not ready after release.
        ready_mode = 0;
        lat_min    = 3;
        lat_max    = 3;
        run_until_outstanding(40);
        cycle();
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("midrst_valid", 32'(if_valid_o), 32'd0);
        chk("midrst_instr", if_instr_o, 32'h0000_0013);
        rst_n      = 1'b1;
        ready_mode = 2;
        cycle();
        repeat (3) begin
            cycle();
            chk("postrst_req_valid", 32'(imem_req_valid_o), 32'd1);
            chk("postrst_addr", imem_addr_o, 32'h0);
        end
        ready_mode = 0;
        lat_min    = 0;
        lat_max    = 0;
        run_until_valid(20);
        chk("postrst_pc", if_pc_o, 32'h0);
        chk("postrst_instr", if_instr_o, 32'h0050_0093);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
